// File: rtl/inst_fetch.sv
// Instruction fetch unit: walks a byte-wide instruction memory with a ready
// handshake and assembles 2-byte (short) or 4-byte (long) big-endian
// instructions. The length is decided by byte 0. A held instruction is
// released to decode with iACCEPT, which also pulses oPCEN so the PC register
// advances on the same edge and the next fetch starts without a bubble.
//
// Optional feature, enabled by defining FETCH_TIMEOUT_EN:
//   a per-byte wait counter raises a sticky oFAULT after TIMEOUT_CYC cycles
//   without MRDY. The FSM then returns to IDLE and retries from F0.
//   Without the macro the FSM waits for MRDY indefinitely and oFAULT is absent.

module inst_fetch #(
    parameter int unsigned LONG_BIT    = 7
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 16
`endif
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] iPC,
    input  logic        iFLUSH,
    input  logic        iACCEPT,
    output logic [31:0] MADDR,
    output logic        MRD,
    input  logic [7:0]  MDATA,
    input  logic        MRDY,
    output logic [31:0] oINST,
    output logic        oULen,
    output logic        oVALID,
    output logic        oPCEN
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic        oFAULT
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StF0,
        StF1,
        StF2,
        StF3,
        StHold
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic        ulen_q, ulen_d;

    logic        in_fetch;
    logic [31:0] addr_off;
    logic        long_b0;

    assign long_b0 = MDATA[LONG_BIT];

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TIMEOUT_CYC + 1);

    logic [WaitW-1:0] wait_q, wait_d;
    logic             fault_q, fault_d;
    logic             timeout;
`endif

    // Decode the fetch phase into a read strobe and a byte offset from iPC.
    always_comb begin
        in_fetch = 1'b0;
        addr_off = 32'd0;
        unique case (state_q)
            StF0: begin
                in_fetch = 1'b1;
                addr_off = 32'd0;
            end
            StF1: begin
                in_fetch = 1'b1;
                addr_off = 32'd1;
            end
            StF2: begin
                in_fetch = 1'b1;
                addr_off = 32'd2;
            end
            StF3: begin
                in_fetch = 1'b1;
                addr_off = 32'd3;
            end
            default: begin
                in_fetch = 1'b0;
                addr_off = 32'd0;
            end
        endcase
    end

    // Memory request outputs; the address is forced to zero outside a fetch.
    always_comb begin
        MRD   = in_fetch;
        MADDR = in_fetch ? (iPC + addr_off) : 32'd0;
    end

    // Next-state and byte assembly; flush wins over both accept and capture.
    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        ulen_d  = ulen_q;
`ifdef FETCH_TIMEOUT_EN
        timeout = 1'b0;
`endif
        if (state_q == StIdle) begin
            state_d = StF0;
        end else if (iFLUSH) begin
            state_d = StF0;
            inst_d  = 32'd0;
            ulen_d  = 1'b0;
        end else begin
            unique case (state_q)
                StF0: begin
                    if (MRDY) begin
                        ulen_d  = long_b0;
                        // Byte 0 lands in the top byte of whichever width it starts.
                        inst_d  = long_b0 ? {MDATA, 24'h0} : {16'h0, MDATA, 8'h0};
                        state_d = StF1;
                    end
                end
                StF1: begin
                    if (MRDY) begin
                        if (ulen_q) begin
                            inst_d[23:16] = MDATA;
                            state_d       = StF2;
                        end else begin
                            inst_d[7:0] = MDATA;
                            state_d     = StHold;
                        end
                    end
                end
                StF2: begin
                    if (MRDY) begin
                        inst_d[15:8] = MDATA;
                        state_d      = StF3;
                    end
                end
                StF3: begin
                    if (MRDY) begin
                        inst_d[7:0] = MDATA;
                        state_d     = StHold;
                    end
                end
                StHold: begin
                    if (iACCEPT) begin
                        state_d = StF0;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
`ifdef FETCH_TIMEOUT_EN
            // This stalled cycle is the one that brings the count to TIMEOUT_CYC.
            if (in_fetch && !MRDY && (wait_q == WaitW'(TIMEOUT_CYC - 1))) begin
                timeout = 1'b1;
                state_d = StIdle;
            end
`endif
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Wait counter restarts on any state change or flush; fault is sticky.
    always_comb begin
        wait_d  = wait_q;
        fault_d = fault_q | timeout;
        if ((state_d != state_q) || iFLUSH) begin
            wait_d = '0;
        end else if (in_fetch && !MRDY) begin
            wait_d = wait_q + WaitW'(1);
        end
    end

    // Timeout state registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    assign oFAULT = fault_q;
`endif

    // Main state and instruction registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= StIdle;
            inst_q  <= 32'd0;
            ulen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            ulen_q  <= ulen_d;
        end
    end

    // Decode-side outputs; oPCEN is a same-cycle pulse on a clean accept.
    always_comb begin
        oINST  = inst_q;
        oULen  = ulen_q;
        oVALID = (state_q == StHold);
        oPCEN  = (state_q == StHold) && iACCEPT && !iFLUSH;
    end

endmodule
